ccff_config_loader: RTL

Configuration-chain loader for the fabric's configuration flip-flop (CCFF) chain, whose bits drive the TGATE `sel`/`selb` pairs and inverter/buffer paths of the routing and LUT multiplexers. It accepts a word-wide bitstream over a valid/ready handshake, serialises it LSB-first onto `ccff_head` with a per-bit shift enable, and counts exactly `CHAIN_LEN` shifts. In optional verify mode it streams the bitstream a second time and compares `ccff_tail` against `ccff_head` bit by bit, flagging any mismatch. It sits between the programming interface and the head and tail of the chain, in the `prog_clk` domain.

---
 rtl/ccff_config_loader_if.sv | 20 ++
 rtl/ccff_config_loader.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ccff_config_loader_if.sv
// Bitstream word handshake between the programming source and the CCFF loader.
interface ccff_config_loader_if #(
    parameter int WORD_W = 8
);
    logic              bs_valid;
    logic [WORD_W-1:0] bs_data;
    logic              bs_ready;

    modport master (
        output bs_valid,
        output bs_data,
        input  bs_ready
    );

    modport slave (
        input  bs_valid,
        input  bs_data,
        output bs_ready
    );
endinterface

// File: rtl/ccff_config_loader.sv
// CCFF chain loader: serialises bitstream words LSB-first onto the chain head,
// counts exactly CHAIN_LEN shifts per pass and optionally re-streams the
// bitstream to compare the chain tail against the head.
module ccff_config_loader #(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 16
) (
    input  logic                 prog_clk,
    input  logic                 pReset,
    input  logic                 start,
    input  logic                 verify,
    input  logic                 abort,
    ccff_config_loader_if.slave  bs,
    output logic                 ccff_head,
    output logic                 ccff_shift_en,
    input  logic                 ccff_tail,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [CNT_W-1:0]     err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CHAIN_CNT = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] WORD_CNT  = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] ZERO      = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE       = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ALL_ONES  = {CNT_W{1'b1}};

    state_t              state_r;
    logic                verify_r;
    logic [CNT_W-1:0]    rem_r;             // shifts still to do in this pass
    logic [CNT_W-1:0]    rem_unassigned_r;  // chain bits not yet covered by a word
    logic [CNT_W-1:0]    bits_left_r;       // valid bits remaining in shreg_r
    logic [WORD_W-1:0]   shreg_r;
    logic                err_r;
    logic [CNT_W-1:0]    err_cnt_r;

    logic                active_s;
    logic                shift_s;
    logic                ready_s;
    logic                hs_s;
    logic                mismatch_s;
    logic [CNT_W-1:0]    take_s;
    logic [CNT_W-1:0]    unassigned_after_s;

    assign active_s           = (state_r == ST_LOAD) || (state_r == ST_VERIFY);
    assign shift_s            = (bits_left_r != ZERO);
    assign ready_s            = active_s && (rem_unassigned_r != ZERO) && (bits_left_r <= ONE);
    assign hs_s               = ready_s && bs.bs_valid;
    assign unassigned_after_s = rem_unassigned_r - take_s;
    assign mismatch_s         = (state_r == ST_VERIFY) && shift_s && (ccff_tail != shreg_r[0]);

    // Bits taken from the next word: a full word, or only the tail of the pass.
    always_comb begin
        take_s = WORD_CNT;
        if (rem_unassigned_r < WORD_CNT) begin
            take_s = rem_unassigned_r;
        end else begin
            take_s = WORD_CNT;
        end
    end

    // Control FSM together with the word buffer, pass counters and error tracking.
    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_r          <= ST_IDLE;
            verify_r         <= 1'b0;
            rem_r            <= ZERO;
            rem_unassigned_r <= ZERO;
            bits_left_r      <= ZERO;
            shreg_r          <= {WORD_W{1'b0}};
            err_r            <= 1'b0;
            err_cnt_r        <= ZERO;
        end else if (abort) begin
            // Stop shifting at once; error status is kept for inspection.
            state_r     <= ST_IDLE;
            bits_left_r <= ZERO;
        end else begin
            if (hs_s) begin
                shreg_r     <= bs.bs_data;
                bits_left_r <= take_s;
                // When pass 1 is fully assigned and a verify pass follows, open
                // pass 2 right away so its first word can follow without a bubble.
                if ((unassigned_after_s == ZERO) && (state_r == ST_LOAD) && verify_r) begin
                    rem_unassigned_r <= CHAIN_CNT;
                end else begin
                    rem_unassigned_r <= unassigned_after_s;
                end
            end else if (shift_s) begin
                shreg_r     <= {1'b0, shreg_r[WORD_W-1:1]};
                bits_left_r <= bits_left_r - ONE;
            end

            if (shift_s) begin
                rem_r <= rem_r - ONE;
            end

            if (mismatch_s) begin
                err_r <= 1'b1;
                if (err_cnt_r != ALL_ONES) begin
                    err_cnt_r <= err_cnt_r + ONE;
                end
            end

            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        verify_r         <= verify;
                        err_r            <= 1'b0;
                        err_cnt_r        <= ZERO;
                        rem_r            <= CHAIN_CNT;
                        rem_unassigned_r <= CHAIN_CNT;
                        bits_left_r      <= ZERO;
                        state_r          <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (shift_s && (rem_r == ONE)) begin
                        if (verify_r) begin
                            rem_r   <= CHAIN_CNT;
                            state_r <= ST_VERIFY;
                        end else begin
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_VERIFY: begin
                    if (shift_s && (rem_r == ONE)) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bs.bs_ready    = ready_s;
    assign ccff_head      = shreg_r[0];
    assign ccff_shift_en  = shift_s;
    assign busy           = active_s;
    assign done           = (state_r == ST_DONE);
    assign err            = err_r;
    assign err_cnt        = err_cnt_r;

endmodule
